bcd_time_counter: RTL

Parametrised MM:SS stopwatch/timer core producing four BCD digits for the seven-segment display driver. It advances on an external 1 Hz tick pulse and supports pause and a field-adjust mode driven by a separate adjust-rate tick. Minute range is configurable, and an optional count-down mode can be compiled in. It sits between the clock-divider block (tick sources) and the display multiplexer.

---
 rtl/bcd_time_pkg.sv | 22 ++
 rtl/bcd_time_counter_if.sv | 39 +++
 rtl/bcd_time_counter_bcd_pair.sv | 70 +++++++
 rtl/bcd_time_counter.sv | 99 +++++++++
 4 files changed

// File: rtl/bcd_time_pkg.sv
// Shared mode enum, BCD digit limits and a tens/ones splitter for the MM:SS counter.
package bcd_time_pkg;

   typedef enum logic [1:0] {
      S_PAUSE = 2'd0,
      S_RUN   = 2'd1,
      S_ADJ   = 2'd2
   } state_e;

   localparam logic [3:0] DIGIT_MAX    = 4'd9;
   localparam logic [3:0] SEC_TENS_MAX = 4'd5;

   // Returns {tens, ones} of a 0..99 value.
   function automatic logic [7:0] split_bcd(int unsigned value);
      logic [3:0] tens;
      logic [3:0] ones;
      tens = 4'(value / 10);
      ones = 4'(value % 10);
      return {tens, ones};
   endfunction

endpackage

// File: rtl/bcd_time_counter_if.sv
// Tick/control inputs and BCD display outputs of bcd_time_counter.
// dir and done exist only when COUNTDOWN_EN is defined.
interface bcd_time_counter_if;

   logic       tick_1hz;
   logic       tick_adj;
   logic       pause;
   logic       adj_min;
   logic       adj_sec;
   logic [3:0] min_tens;
   logic [3:0] min_ones;
   logic [3:0] sec_tens;
   logic [3:0] sec_ones;
   logic       wrap;
   logic [1:0] state_o;
`ifdef COUNTDOWN_EN
   logic       dir;
   logic       done;

   modport master (
      output tick_1hz, tick_adj, pause, adj_min, adj_sec, dir,
      input  min_tens, min_ones, sec_tens, sec_ones, wrap, state_o, done
   );
   modport slave (
      input  tick_1hz, tick_adj, pause, adj_min, adj_sec, dir,
      output min_tens, min_ones, sec_tens, sec_ones, wrap, state_o, done
   );
`else
   modport master (
      output tick_1hz, tick_adj, pause, adj_min, adj_sec,
      input  min_tens, min_ones, sec_tens, sec_ones, wrap, state_o
   );
   modport slave (
      input  tick_1hz, tick_adj, pause, adj_min, adj_sec,
      output min_tens, min_ones, sec_tens, sec_ones, wrap, state_o
   );
`endif

endinterface

// File: rtl/bcd_time_counter_bcd_pair.sv
// Two-digit BCD up/down counter 0..MAX; carry/borrow flag the wrap of the step taken this cycle.
module bcd_pair
   import bcd_time_pkg::*;
#(
   parameter int unsigned MAX = 59
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       inc_i,
   input  logic       dec_i,
   output logic [3:0] tens_o,
   output logic [3:0] ones_o,
   output logic       carry_o,
   output logic       borrow_o
);

   localparam logic [7:0] MAX_BCD  = split_bcd(MAX);
   localparam logic [3:0] MAX_TENS = MAX_BCD[7:4];
   localparam logic [3:0] MAX_ONES = MAX_BCD[3:0];

   logic [3:0] tens_q, tens_d;
   logic [3:0] ones_q, ones_d;
   logic       at_max, at_zero;

   assign at_max   = (tens_q == MAX_TENS) && (ones_q == MAX_ONES);
   assign at_zero  = (tens_q == 4'd0) && (ones_q == 4'd0);
   assign carry_o  = inc_i && at_max;
   assign borrow_o = dec_i && !inc_i && at_zero;

   always_comb begin
      // NOTE: defaults first so every path assigns both digits and no latch is inferred.
      tens_d = tens_q;
      ones_d = ones_q;
      if (inc_i) begin
         if (at_max) begin
            tens_d = 4'd0;
            ones_d = 4'd0;
         end else if (ones_q == DIGIT_MAX) begin
            tens_d = tens_q + 4'd1;
            ones_d = 4'd0;
         end else begin
            ones_d = ones_q + 4'd1;
         end
      end else if (dec_i) begin
         if (at_zero) begin
            tens_d = MAX_TENS;
            ones_d = MAX_ONES;
         end else if (ones_q == 4'd0) begin
            tens_d = tens_q - 4'd1;
            ones_d = DIGIT_MAX;
         end else begin
            ones_d = ones_q - 4'd1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         tens_q <= 4'd0;
         ones_q <= 4'd0;
      end else begin
         tens_q <= tens_d;
         ones_q <= ones_d;
      end
   end

   assign tens_o = tens_q;
   assign ones_o = ones_q;

endmodule

// File: rtl/bcd_time_counter.sv
// MM:SS BCD stopwatch/timer: mode FSM, seconds->minutes carry routing, wrap and done.
// Optional count-down mode (dir input, done flag) is compiled in with COUNTDOWN_EN.
module bcd_time_counter
   import bcd_time_pkg::*;
#(
   parameter int unsigned MAX_MINUTES = 59,
   parameter bit          ADJ_CARRY   = 1'b0
) (
   input logic               clk,
   input logic               rst,
   bcd_time_counter_if.slave bus
);

   state_e     state_q, state_d;
   logic       wrap_q;
   logic       run, adj, down, cnt_zero;
   logic       sec_inc, sec_dec, min_inc, min_dec;
   logic       sec_carry, sec_borrow, min_carry, min_borrow;
   logic [3:0] min_tens, min_ones, sec_tens, sec_ones;
   logic       unused_ok;

   assign run      = (state_q == S_RUN);
   assign adj      = (state_q == S_ADJ);
   assign cnt_zero = (min_tens == 4'd0) && (min_ones == 4'd0) &&
                     (sec_tens == 4'd0) && (sec_ones == 4'd0);

`ifdef COUNTDOWN_EN
   logic done_q, reach_zero;
   assign down       = bus.dir;
   assign reach_zero = sec_dec && (min_tens == 4'd0) && (min_ones == 4'd0) &&
                       (sec_tens == 4'd0) && (sec_ones == 4'd1);
   assign bus.done   = done_q;
`else
   assign down = 1'b0;
`endif

   always_comb begin
      if (bus.adj_min || bus.adj_sec) state_d = S_ADJ;
      else if (bus.pause)             state_d = S_PAUSE;
      else                            state_d = S_RUN;
   end

   // Count-down holds at 00:00 instead of borrowing round to MAX_MINUTES:59.
   assign sec_inc = (run && bus.tick_1hz && !down) || (adj && bus.tick_adj && bus.adj_sec);
   assign sec_dec = run && bus.tick_1hz && down && !cnt_zero;
   assign min_inc = (run && sec_carry) ||
                    (adj && bus.tick_adj && bus.adj_min) ||
                    (adj && ADJ_CARRY && !bus.adj_min && sec_carry);
   assign min_dec = run && sec_borrow;

   bcd_pair #(.MAX(int'(SEC_TENS_MAX) * 10 + int'(DIGIT_MAX))) u_sec (
      .clk      (clk),
      .rst      (rst),
      .inc_i    (sec_inc),
      .dec_i    (sec_dec),
      .tens_o   (sec_tens),
      .ones_o   (sec_ones),
      .carry_o  (sec_carry),
      .borrow_o (sec_borrow)
   );

   bcd_pair #(.MAX(MAX_MINUTES)) u_min (
      .clk      (clk),
      .rst      (rst),
      .inc_i    (min_inc),
      .dec_i    (min_dec),
      .tens_o   (min_tens),
      .ones_o   (min_ones),
      .carry_o  (min_carry),
      .borrow_o (min_borrow)
   );

   assign unused_ok = min_borrow;

   always_ff @(posedge clk) begin
      // NOTE: synchronous reset wins over everything; all state uses non-blocking updates.
      if (rst) begin
         state_q <= S_PAUSE;
         wrap_q  <= 1'b0;
`ifdef COUNTDOWN_EN
         done_q  <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         wrap_q  <= run && min_carry;
`ifdef COUNTDOWN_EN
         done_q  <= (adj || !down) ? 1'b0 : (done_q || reach_zero);
`endif
      end
   end

   assign bus.min_tens = min_tens;
   assign bus.min_ones = min_ones;
   assign bus.sec_tens = sec_tens;
   assign bus.sec_ones = sec_ones;
   assign bus.wrap     = wrap_q;
   assign bus.state_o  = state_q;

endmodule
